i2c_slave: RTL

I2C target (slave) responder for the far end of the bus driven by i2c_master.
- Oversamples SCL/SDA on the system clock, filters them, and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, then receives bytes to a parallel port or transmits bytes fetched by a request/data handshake.
- Drives SDA open-drain only. No clock stretching.

---
 rtl/i2c_slave.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target responder: filtered SCL/SDA, START/STOP detection, 7-bit address
// match, byte receive to a parallel port and byte transmit via request/data handshake.
module i2c_slave #(
    parameter int FILTER_LEN = 3
) (
    input  logic       I_CLK,
    input  logic       I_RSTN,
    input  logic       I_EN,
    input  logic [7:0] I_I2CADR,
    input  logic       I_I2CSCL,
    input  logic       I_I2CSDA,
    output logic       O_SDA_OE,
    input  logic       I_RX_ACK_EN,
    input  logic [7:0] I_TXDATA,
    input  logic       I_TX_VALID,
    output logic       O_TX_REQ,
    output logic [7:0] O_RXDATA,
    output logic       O_RX_VALID,
    output logic       O_AAS,
    output logic       O_SRW,
    output logic       O_RXAK,
    output logic       O_BUSY
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    // bit 0 = SCL, bit 1 = SDA
    logic [1:0]      sync1, sync2, filt, filt_d;
    logic [1:0][2:0] cnt;

    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_d <= '1;
            cnt    <= '0;
        end else begin
            sync1  <= {I_I2CSDA, I_I2CSCL};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == 3'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 3'd1;
                end
            end
        end
    end

    logic sda_f, scl_rise, scl_fall, start, stop;
    assign sda_f    = filt[1];
    assign scl_rise = filt[0] & ~filt_d[0];
    assign scl_fall = ~filt[0] & filt_d[0];
    // SCL must be stably high across the SDA edge, so a coincident SCL edge never counts
    assign start    = filt[0] & filt_d[0] & ~filt[1] & filt_d[1];
    assign stop     = filt[0] & filt_d[0] & filt[1] & ~filt_d[1];

    state_t     state;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       ninth;
    logic [7:0] tx_byte;
    logic       adr_match;

    assign tx_byte   = I_TX_VALID ? I_TXDATA : 8'hFF;
    assign adr_match = ((({shift[6:0], 1'b0}) ^ I_I2CADR) & 8'hFE) == 8'h00;

    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            ninth      <= 1'b0;
            O_SDA_OE   <= 1'b0;
            O_TX_REQ   <= 1'b0;
            O_RXDATA   <= '0;
            O_RX_VALID <= 1'b0;
            O_AAS      <= 1'b0;
            O_SRW      <= 1'b0;
            O_RXAK     <= 1'b0;
            O_BUSY     <= 1'b0;
        end else begin
            O_TX_REQ   <= 1'b0;
            O_RX_VALID <= 1'b0;
            if (start)     O_BUSY <= 1'b1;
            else if (stop) O_BUSY <= 1'b0;

            if (!I_EN) begin
                state    <= IDLE;
                O_SDA_OE <= 1'b0;
                O_AAS    <= 1'b0;
            end else if (start) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                ninth    <= 1'b0;
                O_AAS    <= 1'b0;
                O_SDA_OE <= 1'b0;
            end else if (stop) begin
                state    <= IDLE;
                O_AAS    <= 1'b0;
                O_SDA_OE <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift <= {shift[6:0], sda_f};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            ninth   <= 1'b0;
                            if (adr_match) begin
                                O_SRW <= sda_f;
                                O_AAS <= 1'b1;
                                state <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    // ninth=0: 8th falling edge opens the ACK slot; ninth=1: 9th closes it
                    ADDR_ACK, RX_ACK: if (scl_fall) begin
                        if (!ninth) begin
                            ninth    <= 1'b1;
                            O_SDA_OE <= (state == ADDR_ACK) ? 1'b1 : I_RX_ACK_EN;
                            if (state == ADDR_ACK && O_SRW) O_TX_REQ <= 1'b1;
                        end else begin
                            ninth   <= 1'b0;
                            bit_cnt <= '0;
                            if (state == ADDR_ACK && O_SRW) begin
                                shift    <= tx_byte;
                                O_SDA_OE <= ~tx_byte[7];
                                state    <= TX;
                            end else begin
                                O_SDA_OE <= 1'b0;
                                state    <= RX;
                            end
                        end
                    end
                    RX: if (scl_rise) begin
                        shift <= {shift[6:0], sda_f};
                        if (bit_cnt == 3'd7) begin
                            O_RXDATA   <= {shift[6:0], sda_f};
                            O_RX_VALID <= 1'b1;
                            bit_cnt    <= '0;
                            ninth      <= 1'b0;
                            state      <= RX_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    TX: if (scl_rise) begin
                        if (bit_cnt == 3'd7) ninth <= 1'b1;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end else if (scl_fall) begin
                        if (ninth) begin
                            O_SDA_OE <= 1'b0;
                            state    <= TX_ACK;
                        end else begin
                            shift    <= {shift[6:0], 1'b0};
                            O_SDA_OE <= ~shift[6];
                        end
                    end
                    // ninth drops once the master's ACK is seen; the next fall loads the byte
                    TX_ACK: if (scl_rise) begin
                        O_RXAK <= sda_f;
                        if (sda_f) begin
                            state <= WAIT_STOP;
                        end else begin
                            O_TX_REQ <= 1'b1;
                            ninth    <= 1'b0;
                        end
                    end else if (scl_fall && !ninth) begin
                        shift    <= tx_byte;
                        O_SDA_OE <= ~tx_byte[7];
                        bit_cnt  <= '0;
                        state    <= TX;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
